optical_channel_scheduler: RTL

//   Shares one optical waveguide/wavelength channel among N electrical requesters.

---
 rtl/optical_channel_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/optical_channel_scheduler.sv
// Round-robin arbiter sharing one optical channel among N requesters, with a laser
// settling guard before each grant and a bounded hold time per tenure.
module optical_channel_scheduler #(
  parameter int N            = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         request,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 tx_enable,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_ID    = IW'(N - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE_N      = N'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IW-1:0]   scan_sel_s;
  logic [IW-1:0]   scan_idx_s;
  logic [IW-1:0]   next_id_s;
  logic            owner_req_s;
  logic            owner_done_s;

  // Circular scan from ptr: walking offsets downward lets the nearest requester win.
  always_comb begin
    scan_sel_s = ptr_q;
    scan_idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx_s = IW'((int'(ptr_q) + i) % N);
      scan_sel_s = request[scan_idx_s] ? scan_idx_s : scan_sel_s;
    end
  end

  assign next_id_s    = (owner_q == LAST_ID) ? '0 : owner_q + IW'(1);
  assign owner_req_s  = request[owner_q];
  assign owner_done_s = done[owner_q];

  // Next-state logic for tenure selection, settling guard and hold limit.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    guard_cnt_d = guard_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|request) begin
          owner_d     = scan_sel_s;
          guard_cnt_d = '0;
          if (GUARD_CYCLES == 0) begin
            state_d    = S_GRANT;
            hold_cnt_d = HW'(1);
          end else begin
            state_d    = S_GUARD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GUARD: begin
        if (!owner_req_s) begin
          state_d     = S_IDLE;
          ptr_d       = next_id_s;
          guard_cnt_d = '0;
        end else if (guard_cnt_q == GUARD_LAST) begin
          state_d     = S_GRANT;
          hold_cnt_d  = HW'(1);
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      S_GRANT: begin
        if (owner_done_s || !owner_req_s || (hold_cnt_q == HOLD_MAX)) begin
          state_d    = S_IDLE;
          ptr_d      = next_id_s;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        ptr_d       = '0;
        owner_d     = '0;
        guard_cnt_d = '0;
        hold_cnt_d  = '0;
      end
    endcase
    grant_valid_d = (state_d == S_GRANT);
    grant_d       = grant_valid_d ? (ONE_N << owner_d) : '0;
  end

  // State and output registers; reset forces the transmitter off immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      guard_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      guard_cnt_q   <= guard_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = owner_q;
  assign tx_enable   = grant_valid_q;
  // A done on the final permitted cycle is a normal exit, not a timeout.
  assign timeout     = (state_q == S_GRANT) && (hold_cnt_q == HOLD_MAX) && !owner_done_s;

endmodule
